// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: issues data-memory requests from the EX/MEM register,
// aligns load/store data, and drives the MEM/WB register and upstream stall.
module memory_access_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] alu_out_ex_mem_i,
    input  logic [31:0] rs2_ex_mem_i,
    input  logic [4:0]  rd_ex_mem_i,
    input  logic [2:0]  funct3_ex_mem_i,
    input  logic [1:0]  wb_sel_ex_mem_i,
    input  logic        is_load_instr_ex_mem_i,
    input  logic        is_store_instr_ex_mem_i,
    input  logic        mul_stall_i,
    input  logic        div_stall_i,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [29:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        busywait_o,
    output logic        misaligned_o,
    output logic [4:0]  rd_mem_wb_o,
    output logic [31:0] alu_out_mem_wb_o,
    output logic [31:0] rd_data_mem_wb_o,
    output logic [1:0]  wb_sel_mem_wb_o,
    output logic        is_load_instr_mem_wb_o
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic        done_q, done_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] load_data_q, load_data_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [1:0]  wb_sel_q, wb_sel_d;
    logic        is_load_q, is_load_d;

    logic        is_mem;
    logic        aligned;
    logic        pending;
    logic        ack_ok;
    logic [1:0]  offset;
    logic [7:0]  rdata_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_fmt;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rdata_byte[gi] = mem_rdata_i[8*gi +: 8];
        end
    endgenerate

    assign offset = alu_out_ex_mem_i[1:0];

    always_comb begin
        is_mem = is_load_instr_ex_mem_i || is_store_instr_ex_mem_i;
        case (funct3_ex_mem_i[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = !offset[0];
            default: aligned = (offset == 2'b00);
        endcase
        pending = is_mem && aligned && !done_q;
        // An acknowledge only counts when it answers a live request.
        ack_ok  = mem_ack_i && pending;
    end

    always_comb begin
        sel_byte = rdata_byte[offset];
        sel_half = offset[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (funct3_ex_mem_i)
            3'b000:  load_fmt = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_fmt = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_fmt = {24'd0, sel_byte};
            3'b101:  load_fmt = {16'd0, sel_half};
            default: load_fmt = mem_rdata_i;
        endcase
    end

    always_comb begin
        mem_req_o   = pending;
        mem_we_o    = pending && is_store_instr_ex_mem_i;
        mem_addr_o  = alu_out_ex_mem_i[31:2];
        busywait_o  = pending && !mem_ack_i;
        mem_be_o    = 4'b0000;
        if (pending) begin
            case (funct3_ex_mem_i[1:0])
                2'b00:   mem_be_o = 4'b0001 << offset;
                2'b01:   mem_be_o = 4'b0011 << offset;
                default: mem_be_o = 4'b1111;
            endcase
        end
        case (funct3_ex_mem_i[1:0])
            2'b00:   mem_wdata_o = {4{rs2_ex_mem_i[7:0]}};
            2'b01:   mem_wdata_o = {2{rs2_ex_mem_i[15:0]}};
            default: mem_wdata_o = rs2_ex_mem_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (pending && !mem_ack_i) state_d = S_WAIT;
            S_WAIT: if (!pending || mem_ack_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Remember a completed access while the EX stall keeps the same instruction here.
        done_d       = (ack_ok || done_q) && (mul_stall_i || div_stall_i) && !flush_i;
        load_data_d  = ack_ok ? load_fmt : load_data_q;
        misaligned_d = is_mem && !aligned;

        alu_d     = alu_out_ex_mem_i;
        wb_sel_d  = wb_sel_ex_mem_i;
        rd_data_d = load_data_d;
        if (busywait_o) begin
            rd_d      = 5'd0;
            is_load_d = 1'b0;
        end else begin
            rd_d      = (is_store_instr_ex_mem_i || misaligned_d) ? 5'd0 : rd_ex_mem_i;
            is_load_d = is_load_instr_ex_mem_i && aligned;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            load_data_q  <= 32'd0;
            rd_q         <= 5'd0;
            alu_q        <= 32'd0;
            rd_data_q    <= 32'd0;
            wb_sel_q     <= 2'd0;
            is_load_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            misaligned_q <= misaligned_d;
            load_data_q  <= load_data_d;
            rd_q         <= rd_d;
            alu_q        <= alu_d;
            rd_data_q    <= rd_data_d;
            wb_sel_q     <= wb_sel_d;
            is_load_q    <= is_load_d;
        end
    end

    assign misaligned_o           = misaligned_q;
    assign rd_mem_wb_o            = rd_q;
    assign alu_out_mem_wb_o       = alu_q;
    assign rd_data_mem_wb_o       = rd_data_q;
    assign wb_sel_mem_wb_o        = wb_sel_q;
    assign is_load_instr_mem_wb_o = is_load_q;

endmodule

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 The block SHALL have no parameters; one clock, clk_i; reset rst_i is synchronous and active-high.
REQ-002 clk_i  in  1  clock; all state updates on rising edge.
REQ-003 rst_i  in  1  synchronous active-high reset.
REQ-004 alu_out_ex_mem_i  in  32  effective address, or ALU result for non-memory instructions.
REQ-005 rs2_ex_mem_i  in  32  store data, unaligned (bits [7:0]/[15:0]/[31:0]).
REQ-006 rd_ex_mem_i  in  5  destination register; 0 = no writeback.
REQ-007 funct3_ex_mem_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 wb_sel_ex_mem_i  in  2  writeback source select, passed through.
REQ-009 is_load_instr_ex_mem_i / is_store_instr_ex_mem_i  in  1 each  access type.
REQ-010 mul_stall_i, div_stall_i  in  1 each  EX-stage MDU stalls; EX/MEM register holds while high.
REQ-011 flush_i  in  1  EX branching; EX/MEM register is cleared at this edge.
REQ-012 mem_req_o  out  1  data-memory request.
REQ-013 mem_we_o  out  1  1 = write.
REQ-014 mem_addr_o  out  30  word address (alu_out_ex_mem_i[31:2]).
REQ-015 mem_be_o  out  4  byte enables.
REQ-016 mem_wdata_o  out  32  lane-replicated store data.
REQ-017 mem_rdata_i  in  32  read word; valid when mem_ack_i=1.
REQ-018 mem_ack_i  in  1  access complete; may arrive in the request cycle.
REQ-019 busywait_o  out  1  combinational stall to all upstream stages.
REQ-020 misaligned_o  out  1  registered one-cycle misaligned-access flag.
REQ-021 rd_mem_wb_o (5), alu_out_mem_wb_o (32), rd_data_mem_wb_o (32), wb_sel_mem_wb_o (2), is_load_instr_mem_wb_o (1)  out  MEM/WB register.

Function
REQ-022 pending = (load|store) && aligned && !done; mem_req_o = pending; busywait_o = pending && !mem_ack_i.
REQ-023 FSM: IDLE -> WAIT when pending && !mem_ack_i; WAIT -> IDLE on mem_ack_i; WAIT holds mem_req_o and all memory outputs stable.
REQ-024 done flag: next = (mem_ack_i || done) && (mul_stall_i || div_stall_i) && !flush_i; prevents re-issuing an already-completed access while EX/MEM holds.
REQ-025 Alignment: H requires addr[0]=0, W requires addr[1:0]=0; a misaligned access issues no request, causes no busywait, sets misaligned_o=1 next cycle, and writes rd_mem_wb_o=0.
REQ-026 Byte enables: B 0001<<addr[1:0]; H 0011<<addr[1:0]; W 1111; mem_be_o=0 when no request.
REQ-027 Store data: B replicated ×4, H replicated ×2, W as-is.
REQ-028 Load data: select byte/half by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W as-is.
REQ-029 MEM/WB updates on every edge with busywait_o=0; during busywait_o=1, rd_mem_wb_o and is_load_instr_mem_wb_o load 0 (bubble), other fields are don't-care.
REQ-030 Latency: zero-wait memory (ack in request cycle) gives 0 stall cycles; N wait cycles give N busywait cycles.
REQ-031 A store writes rd_mem_wb_o=0; non-memory instructions pass through with 0 stall.
REQ-032 mem_ack_i without mem_req_o SHALL be ignored.

Reset
REQ-033 On rst_i: FSM=IDLE, done=0, misaligned_o=0, all MEM/WB outputs 0; mem_req_o drops in the following cycle even mid-WAIT; a late ack is ignored.

Verification
REQ-034 LB at addr 0x103, mem_rdata_i=0x80FF_FF00, ack in the same cycle -> busywait_o=0; next cycle rd_data_mem_wb_o=0xFFFF_FF80.
REQ-035 SH at 0x202, rs2=0x1234_ABCD, ack after 3 cycles -> mem_be_o=1100, mem_wdata_o=0xABCD_ABCD, busywait_o=1 for 3 cycles, rd_mem_wb_o=0 during the stall.
REQ-036 LW at 0x006 -> mem_req_o=0, busywait_o=0, misaligned_o=1 for one cycle, rd_mem_wb_o=0.
REQ-037 LHU acked while mul_stall_i=1 for 4 cycles -> exactly one mem_req_o pulse; no re-issue.
REQ-038 rst_i asserted in WAIT -> mem_req_o=0 the next cycle, all outputs 0; an ack arriving afterwards has no effect.
